// File: rtl/core_pkg.sv
// core_pkg: shared encodings for the RV32I-subset multi-cycle core.
//   Opcode constants (also used by the immediate generator), datapath
//   select encodings and the control FSM state enum.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;

  localparam logic [1:0] PC_ALU    = 2'd0;  // live ALU result (PC+4)
  localparam logic [1:0] PC_ALUOUT = 2'd1;  // target computed in DECODE
  localparam logic [1:0] PC_JALR   = 2'd2;  // ALU result with bit 0 cleared

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational instruction classifier.
//   opcode, funct3, funct7_5 in -> aluOp (operation for R/I ALU ops) and
//   legal (instruction is in the supported subset).
module alu_decoder
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] aluOp,
  output logic       legal
);

  always_comb begin
    aluOp = ALU_ADD;
    legal = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          3'b000: begin aluOp = funct7_5 ? ALU_SUB : ALU_ADD; legal = 1'b1; end
          3'b111: begin aluOp = ALU_AND; legal = !funct7_5; end
          3'b110: begin aluOp = ALU_OR;  legal = !funct7_5; end
          3'b001: begin aluOp = ALU_SLL; legal = !funct7_5; end
          3'b101: begin aluOp = ALU_SRL; legal = !funct7_5; end // sra rejected
          default: ;
        endcase
      end
      OP_IMM: begin
        // funct7_5 is an immediate bit for addi/andi, only shifts look at it
        case (funct3)
          3'b000: begin aluOp = ALU_ADD; legal = 1'b1; end
          3'b111: begin aluOp = ALU_AND; legal = 1'b1; end
          3'b001: begin aluOp = ALU_SLL; legal = !funct7_5; end
          3'b101: begin aluOp = ALU_SRL; legal = !funct7_5; end
          default: ;
        endcase
      end
      OP_LOAD:   legal = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b100);
      OP_STORE:  legal = (funct3 == 3'b000) || (funct3 == 3'b010);
      OP_BRANCH: legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                         (funct3 == 3'b100) || (funct3 == 3'b101);
      OP_JAL:    legal = 1'b1;
      OP_JALR:   legal = (funct3 == 3'b000);
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control FSM of the multi-cycle RV32I-subset core.
//   In : clk, rst_n (sync, active low), instr (IR), branchTaken, memReady.
//   Out: memory handshake (memReq/memWe/memSize/memUnsigned/iOrD),
//        datapath strobes and selects (irWrite, pcWrite, pcSrc, aluSrcA,
//        aluSrcB, aluOp, regWrite, wbSel), halted (sticky trap), instret.
//   MEM_TIMEOUT: consecutive unanswered memReq cycles before trapping
//   (0 disables the timeout).
module multi_cycle_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        branchTaken,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWe,
  output logic [1:0]  memSize,
  output logic        memUnsigned,
  output logic        iOrD,
  output logic        irWrite,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  aluOp,
  output logic        regWrite,
  output logic [1:0]  wbSel,
  output logic        halted,
  output logic [31:0] instret
);

  localparam int            TW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e        state, nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          retire;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [2:0]    dec_op;
  logic          dec_legal;
  logic          is_load, is_store;
  logic          unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign is_load      = (opcode == OP_LOAD);
  assign is_store     = (opcode == OP_STORE);
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  assign halted       = (state == S_TRAP);

  alu_decoder u_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (instr[30]),
    .aluOp    (dec_op),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      tcnt    <= '0;
      instret <= '0;
    end else begin
      state   <= nxt;
      tcnt    <= tcnt_nxt;
      instret <= instret + {31'd0, retire};
    end
  end

  always_comb begin
    nxt         = state;
    tcnt_nxt    = '0;
    retire      = 1'b0;
    memReq      = 1'b0;
    memWe       = 1'b0;
    memSize     = 2'd0;
    memUnsigned = 1'b0;
    iOrD        = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcSrc       = PC_ALU;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_RS2;
    aluOp       = ALU_ADD;
    regWrite    = 1'b0;
    wbSel       = WB_ALU;

    case (state)
      S_FETCH: begin
        memReq  = 1'b1;
        memSize = SZ_WORD;
        aluSrcB = SRCB_FOUR;          // PC+4 on the ALU while waiting
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMM;           // oldPc+imm lands in aluOut for branch/jal
        nxt     = dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            aluSrcA = 1'b1;
            aluOp   = dec_op;
            nxt     = S_WB;
          end
          OP_IMM: begin
            aluSrcA = 1'b1;
            aluSrcB = SRCB_IMM;
            aluOp   = dec_op;
            nxt     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            aluSrcA = 1'b1;
            aluSrcB = SRCB_IMM;
            nxt     = S_MEM;
          end
          OP_BRANCH: begin
            aluSrcA = 1'b1;
            aluOp   = ALU_SUB;
            if (branchTaken) begin
              pcWrite = 1'b1;
              pcSrc   = PC_ALUOUT;
            end
            retire  = 1'b1;
            nxt     = S_FETCH;
          end
          OP_JAL: begin
            pcWrite  = 1'b1;
            pcSrc    = PC_ALUOUT;
            regWrite = 1'b1;            // link value is the pre-update PC
            wbSel    = WB_PC;
            retire   = 1'b1;
            nxt      = S_FETCH;
          end
          OP_JALR: begin
            aluSrcA  = 1'b1;
            aluSrcB  = SRCB_IMM;
            pcWrite  = 1'b1;
            pcSrc    = PC_JALR;
            regWrite = 1'b1;
            wbSel    = WB_PC;
            retire   = 1'b1;
            nxt      = S_FETCH;
          end
          default: nxt = S_TRAP;      // DECODE already filters these
        endcase
      end
      S_MEM: begin
        memReq      = 1'b1;
        iOrD        = 1'b1;
        memWe       = is_store;
        memSize     = funct3[1:0];
        memUnsigned = funct3[2];
        if (memReady) begin
          if (is_store) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        wbSel    = is_load ? WB_MEM : WB_ALU;
        retire   = 1'b1;
        nxt      = S_FETCH;
      end
      S_TRAP: ;
      default: nxt = S_FETCH;
    endcase

    // Stall watchdog: tcnt_nxt defaults to 0, so any state change or
    // memReady clears it; only an unanswered request keeps it counting.
    if (memReq && !memReady && (MEM_TIMEOUT != 0)) begin
      if (tcnt == T_LAST) nxt = S_TRAP;
      else                tcnt_nxt = tcnt + 1'b1;
    end

    // Quiet the bus and all strobes for as long as reset is held.
    if (!rst_n) begin
      memReq   = 1'b0;
      memWe    = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      regWrite = 1'b0;
      retire   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: hand vector table, randomized instructions
// against a transaction-level reference model, reset corner sequences.
module tb_multi_cycle_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        branchTaken = 1'b0;
  logic        memReady = 1'b0;
  logic        memReq, memWe, memUnsigned, iOrD, irWrite, pcWrite;
  logic        aluSrcA, regWrite, halted;
  logic [1:0]  memSize, pcSrc, aluSrcB, wbSel;
  logic [2:0]  aluOp;
  logic [31:0] instret;

  multi_cycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branchTaken(branchTaken),
    .memReady(memReady), .memReq(memReq), .memWe(memWe), .memSize(memSize),
    .memUnsigned(memUnsigned), .iOrD(iOrD), .irWrite(irWrite), .pcWrite(pcWrite),
    .pcSrc(pcSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .regWrite(regWrite), .wbSel(wbSel), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // One instruction: stimulus (instr, bt, fetch/mem wait cycles) and the
  // observable summary expected over its lifetime.
  typedef struct {
    logic [31:0] instr;
    bit bt; int fw; int mw;
    bit trap; int cyc; int rw; int pcw; int mreq; int mwe;
    int wbsel; int aluop; int pcsrc; int msize; int muns; int both;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; memReady = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Reference: name the instruction, then derive its costs from the
  // architectural rules (fetch, decode, per-class execute path, waits).
  function automatic string mnem(input logic [31:0] i);
    logic [2:0] f3;
    bit f7;
    f3 = i[14:12];
    f7 = i[30];
    case (i[6:0])
      7'h33: case (f3)
        3'd0: return f7 ? "sub" : "add";
        3'd7: return f7 ? "ill" : "and";
        3'd6: return f7 ? "ill" : "or";
        3'd1: return f7 ? "ill" : "sll";
        3'd5: return f7 ? "ill" : "srl";
        default: return "ill";
      endcase
      7'h13: case (f3)
        3'd0: return "addi";
        3'd7: return "andi";
        3'd1: return f7 ? "ill" : "slli";
        3'd5: return f7 ? "ill" : "srli";
        default: return "ill";
      endcase
      7'h03: return (f3 == 3'd2) ? "lw" : (f3 == 3'd0) ? "lb" : (f3 == 3'd4) ? "lbu" : "ill";
      7'h23: return (f3 == 3'd2) ? "sw" : (f3 == 3'd0) ? "sb" : "ill";
      7'h63: return (f3 == 3'd0) ? "beq" : (f3 == 3'd1) ? "bne" :
                    (f3 == 3'd5) ? "bge" : (f3 == 3'd4) ? "blt" : "ill";
      7'h6F: return "jal";
      7'h67: return (f3 == 3'd0) ? "jalr" : "ill";
      default: return "ill";
    endcase
  endfunction

  function automatic vec_t model(input logic [31:0] i, input bit bt, input int fw, input int mw);
    vec_t v;
    string m;
    bit ld, st, br, jmp, alu;
    v = '{default: 0};
    v.instr = i; v.bt = bt; v.fw = fw; v.mw = mw;
    m = mnem(i);
    if (fw >= TO) begin v.trap = 1; v.cyc = TO; return v; end
    if (m == "ill") begin v.trap = 1; v.cyc = fw + 2; return v; end
    ld  = (m == "lw") || (m == "lb") || (m == "lbu");
    st  = (m == "sw") || (m == "sb");
    br  = (m == "beq") || (m == "bne") || (m == "bge") || (m == "blt");
    jmp = (m == "jal") || (m == "jalr");
    alu = !(ld || st || br || jmp);
    if ((ld || st) && mw >= TO) begin v.trap = 1; v.cyc = fw + 3 + TO; return v; end
    v.pcw  = 1 + ((jmp || (br && bt)) ? 1 : 0);
    v.mreq = fw + 1 + ((ld || st) ? mw + 1 : 0);
    v.mwe  = st ? mw + 1 : 0;
    v.cyc  = alu ? fw + 4 : ld ? fw + mw + 5 : st ? fw + mw + 4 : fw + 3;
    v.rw   = (alu || ld || jmp) ? 1 : 0;
    v.wbsel = ld ? 1 : jmp ? 2 : 0;
    v.pcsrc = (m == "jalr") ? 2 : ((m == "jal") || (br && bt)) ? 1 : 0;
    v.msize = ((m == "lw") || (m == "sw")) ? 2 : 0;
    v.muns  = (m == "lbu") ? 1 : 0;
    v.both  = jmp ? 1 : 0;
    if ((m == "sub") || br)                 v.aluop = 1;
    else if ((m == "and") || (m == "andi")) v.aluop = 2;
    else if (m == "or")                     v.aluop = 3;
    else if ((m == "sll") || (m == "slli")) v.aluop = 4;
    else if ((m == "srl") || (m == "srli")) v.aluop = 5;
    return v;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] r;
    logic [6:0] op, f7;
    logic [2:0] f3;
    int k;
    r = $urandom;
    k = $urandom_range(0, 24);
    f7 = r[31:25];
    f3 = r[14:12];
    op = 7'h7F;
    case (k)
      0:  begin op = 7'h33; f3 = 3'd0; f7 = 7'h00; end
      1:  begin op = 7'h33; f3 = 3'd0; f7 = 7'h20; end
      2:  begin op = 7'h33; f3 = 3'd7; f7 = 7'h00; end
      3:  begin op = 7'h33; f3 = 3'd6; f7 = 7'h00; end
      4:  begin op = 7'h33; f3 = 3'd1; f7 = 7'h00; end
      5:  begin op = 7'h33; f3 = 3'd5; f7 = 7'h00; end
      6:  begin op = 7'h13; f3 = 3'd0; end
      7:  begin op = 7'h13; f3 = 3'd7; end
      8:  begin op = 7'h13; f3 = 3'd1; f7 = 7'h00; end
      9:  begin op = 7'h13; f3 = 3'd5; f7 = 7'h00; end
      10: begin op = 7'h03; f3 = 3'd2; end
      11: begin op = 7'h03; f3 = 3'd0; end
      12: begin op = 7'h03; f3 = 3'd4; end
      13: begin op = 7'h23; f3 = 3'd2; end
      14: begin op = 7'h23; f3 = 3'd0; end
      15: begin op = 7'h63; f3 = 3'd0; end
      16: begin op = 7'h63; f3 = 3'd1; end
      17: begin op = 7'h63; f3 = 3'd5; end
      18: begin op = 7'h63; f3 = 3'd4; end
      19: op = 7'h6F;
      20: begin op = 7'h67; f3 = 3'd0; end
      21: begin op = 7'h13; f3 = 3'd5; f7 = 7'h20; end
      22: begin op = 7'h13; f3 = 3'd6; end
      23: begin op = 7'h03; f3 = 3'd1; end
      default: op = (r[0]) ? 7'h37 : 7'h17;
    endcase
    return {f7, r[24:15], f3, r[11:7], op};
  endfunction

  // Drive one instruction from FETCH to retire/trap and compare the
  // observed cycle-by-cycle behaviour against the vector's expectations.
  task automatic run(input vec_t v, input string tag);
    int cyc, rw, pcw, mreq, mwe, wbsel, aluop, pcsrc, msize, muns, irw, both, wcnt;
    logic [31:0] start;
    bit done;
    cyc = 0; rw = 0; pcw = 0; mreq = 0; mwe = 0; wbsel = 0; aluop = 0;
    pcsrc = 0; msize = 0; muns = 0; irw = 0; both = 0; wcnt = 0; done = 0;
    start = instret;
    instr = v.instr;
    branchTaken = v.bt;
    while (!done && cyc < 64) begin
      @(negedge clk);
      memReady = memReq ? (wcnt >= (iOrD ? v.mw : v.fw)) : 1'b0;
      #1;
      cyc++;
      if (regWrite) begin rw++; wbsel = wbSel; end
      if (pcWrite) begin pcw++; if (!memReq) pcsrc = pcSrc; end
      if (regWrite && pcWrite) both++;
      if (memReq) begin
        mreq++;
        if (memWe) mwe++;
        if (iOrD) begin msize = memSize; muns = memUnsigned; end
      end
      if (irWrite) irw++;
      if (cyc == v.fw + 3) aluop = aluOp;
      wcnt = (memReq && !memReady) ? wcnt + 1 : 0;
      @(posedge clk); #1;
      done = (instret != start) || halted;
    end
    memReady = 1'b0;
    chk({tag, ".finished"}, done, 1);
    chk({tag, ".cycles"}, cyc, v.cyc);
    chk({tag, ".halted"}, halted, v.trap);
    chk({tag, ".instret_delta"}, instret - start, v.trap ? 0 : 1);
    if (!v.trap) begin
      chk({tag, ".irWrite_cnt"}, irw, 1);
      chk({tag, ".regWrite_cnt"}, rw, v.rw);
      chk({tag, ".pcWrite_cnt"}, pcw, v.pcw);
      chk({tag, ".memReq_cnt"}, mreq, v.mreq);
      chk({tag, ".memWe_cnt"}, mwe, v.mwe);
      chk({tag, ".wbSel"}, wbsel, v.wbsel);
      chk({tag, ".aluOp_exec"}, aluop, v.aluop);
      chk({tag, ".pcSrc_exec"}, pcsrc, v.pcsrc);
      chk({tag, ".memSize"}, msize, v.msize);
      chk({tag, ".memUnsigned"}, muns, v.muns);
      chk({tag, ".rw_pcw_same_cycle"}, both, v.both);
    end else begin
      @(negedge clk); #1;
      chk({tag, ".trap_memReq"}, memReq, 0);
      chk({tag, ".trap_sticky"}, halted, 1);
      do_reset();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // instr, bt, fw, mw, trap, cyc, rw, pcw, mreq, mwe, wbsel, aluop, pcsrc, msize, muns, both
    tbl.push_back('{32'h002081B3, 0, 0, 0,  0, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0}); // add
    tbl.push_back('{32'h402081B3, 0, 0, 0,  0, 4, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0}); // sub
    tbl.push_back('{32'h0080A283, 0, 0, 3,  0, 8, 1, 1, 5, 0, 1, 0, 0, 2, 0, 0}); // lw, 3 waits
    tbl.push_back('{32'h0000C283, 0, 1, 0,  0, 6, 1, 1, 3, 0, 1, 0, 0, 0, 1, 0}); // lbu, fetch wait
    tbl.push_back('{32'h0020A223, 0, 0, 0,  0, 4, 0, 1, 2, 1, 0, 0, 0, 2, 0, 0}); // sw
    tbl.push_back('{32'h00208223, 0, 0, 2,  0, 6, 0, 1, 4, 3, 0, 0, 0, 0, 0, 0}); // sb, 2 waits
    tbl.push_back('{32'h00208463, 1, 0, 0,  0, 3, 0, 2, 1, 0, 0, 1, 1, 0, 0, 0}); // beq taken
    tbl.push_back('{32'h00208463, 0, 0, 0,  0, 3, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0}); // beq not taken
    tbl.push_back('{32'h010000EF, 0, 0, 0,  0, 3, 1, 2, 1, 0, 2, 0, 1, 0, 0, 1}); // jal
    tbl.push_back('{32'h000100E7, 0, 0, 0,  0, 3, 1, 2, 1, 0, 2, 0, 2, 0, 0, 1}); // jalr
    tbl.push_back('{32'h00309093, 0, 0, 0,  0, 4, 1, 1, 1, 0, 0, 4, 0, 0, 0, 0}); // slli
    tbl.push_back('{32'h0020E1B3, 0, 0, 0,  0, 4, 1, 1, 1, 0, 0, 3, 0, 0, 0, 0}); // or
    tbl.push_back('{32'h0020D1B3, 0, 0, 0,  0, 4, 1, 1, 1, 0, 0, 5, 0, 0, 0, 0}); // srl
    tbl.push_back('{32'hFFF0F193, 0, 0, 0,  0, 4, 1, 1, 1, 0, 0, 2, 0, 0, 0, 0}); // andi imm=-1
    tbl.push_back('{32'h00209463, 1, 2, 0,  0, 5, 0, 2, 3, 0, 0, 1, 1, 0, 0, 0}); // bne taken, 2 fetch waits
    tbl.push_back('{32'h0000007F, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}); // opcode 0x7F
    tbl.push_back('{32'h4030D093, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}); // srai
    tbl.push_back('{32'h0010E093, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}); // ori
    tbl.push_back('{32'h0080A283, 0, 0, 16, 1, 19, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}); // lw data timeout
    tbl.push_back('{32'h002081B3, 0, 16, 0, 1, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}); // fetch timeout

    // Reset state, then first FETCH cycle after release.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst.memReq", memReq, 0);
    chk("rst.memWe", memWe, 0);
    chk("rst.irWrite", irWrite, 0);
    chk("rst.pcWrite", pcWrite, 0);
    chk("rst.regWrite", regWrite, 0);
    chk("rst.halted", halted, 0);
    chk("rst.instret", instret, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("fetch.memReq", memReq, 1);
    chk("fetch.iOrD", iOrD, 0);
    chk("fetch.memSize", memSize, 2);
    chk("fetch.aluSrcB", aluSrcB, 2);
    chk("fetch.aluOp", aluOp, 0);
    @(posedge clk); #1;  // one unanswered FETCH cycle, then start clean
    do_reset();

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    for (int k = 0; k < 300; k++) begin
      logic [31:0] ri;
      bit rbt;
      int rfw, rmw;
      ri  = gen();
      rbt = bit'($urandom_range(0, 1));
      rfw = $urandom_range(0, 2);
      rmw = ($urandom_range(0, 39) == 0) ? TO : $urandom_range(0, 3);
      run(model(ri, rbt, rfw, rmw), $sformatf("rnd%0d", k));
    end

    // Make sure instret is nonzero so the mid-access reset clear is visible.
    run(tbl[0], "pre_rst_add");
    chk("pre_rst.instret_nonzero", instret != 0, 1);
    instr = 32'h0080A283;                       // lw, stalled in MEM
    @(negedge clk); memReady = 1'b1;            // FETCH
    @(negedge clk); memReady = 1'b0;            // DECODE
    @(negedge clk);                             // EXEC
    @(negedge clk); #1;                         // MEM wait 1
    chk("midrst.memReq_mem", memReq, 1);
    chk("midrst.iOrD_mem", iOrD, 1);
    chk("midrst.memSize_mem", memSize, 2);
    @(negedge clk); rst_n = 1'b0;               // MEM wait 2, reset asserted
    @(posedge clk); #1;
    chk("midrst.memReq", memReq, 0);
    chk("midrst.instret", instret, 0);
    chk("midrst.halted", halted, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("midrst.fetch_memReq", memReq, 1);
    chk("midrst.fetch_iOrD", iOrD, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
